// File: rtl/sliding_window_argmin.sv
// Streaming arg-min: one register stage forms A*T, a second stage selects the
// minimum product over the last WIN accepted records and presents its account.
module sliding_window_argmin #(
  parameter int  DSIZE      = 8,
  parameter int  WIN        = 5,
  parameter int  TIE_NEWEST = 1,
  localparam int IW         = $clog2(WIN),
  localparam int PW         = 2 * DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_account,
  input  logic [DSIZE-1:0] in_A,
  input  logic [DSIZE-1:0] in_T,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_account,
  output logic [PW-1:0]    out_min,
  output logic [IW-1:0]    out_idx
);

  localparam logic [IW-1:0] FILL_MAX = IW'(WIN - 1);

  logic             ready_en_q, ready_en_d;
  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_prod_q, s1_prod_d;
  logic [DSIZE-1:0] s1_acct_q, s1_acct_d;
  logic [IW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    hist_prod_q [WIN-1];
  logic [PW-1:0]    hist_prod_d [WIN-1];
  logic [DSIZE-1:0] hist_acct_q [WIN-1];
  logic [DSIZE-1:0] hist_acct_d [WIN-1];
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_account_q, out_account_d;
  logic [PW-1:0]    out_min_q, out_min_d;
  logic [IW-1:0]    out_idx_q, out_idx_d;

  logic             adv;
  logic             xfer;
  logic [PW-1:0]    cand_prod [WIN];
  logic [DSIZE-1:0] cand_acct [WIN];
  logic [PW-1:0]    best_prod;
  logic [DSIZE-1:0] best_acct;
  logic [IW-1:0]    best_idx;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && ready_en_q && !clear;
  assign xfer     = in_valid && in_ready;

  // Candidate index 0 is the oldest history entry; the S1 record is the newest.
  always_comb begin : argmin
    for (int i = 0; i < WIN - 1; i++) begin
      cand_prod[i] = hist_prod_q[i];
      cand_acct[i] = hist_acct_q[i];
    end
    cand_prod[WIN-1] = s1_prod_q;
    cand_acct[WIN-1] = s1_acct_q;

    best_prod = cand_prod[0];
    best_acct = cand_acct[0];
    best_idx  = '0;
    for (int i = 1; i < WIN; i++) begin
      if ((TIE_NEWEST != 0) ? (cand_prod[i] <= best_prod) : (cand_prod[i] < best_prod)) begin
        best_prod = cand_prod[i];
        best_acct = cand_acct[i];
        best_idx  = IW'(i);
      end
    end
  end

  always_comb begin : next_state
    ready_en_d    = 1'b1;
    s1_valid_d    = s1_valid_q;
    s1_prod_d     = s1_prod_q;
    s1_acct_d     = s1_acct_q;
    fill_d        = fill_q;
    out_valid_d   = out_valid_q;
    out_account_d = out_account_q;
    out_min_d     = out_min_q;
    out_idx_d     = out_idx_q;
    for (int i = 0; i < WIN - 1; i++) begin
      hist_prod_d[i] = hist_prod_q[i];
      hist_acct_d[i] = hist_acct_q[i];
    end

    if (clear) begin
      fill_d      = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (adv) begin
      s1_valid_d = xfer;
      s1_prod_d  = PW'(in_A) * PW'(in_T);
      s1_acct_d  = in_account;
      if (s1_valid_q) begin
        out_valid_d   = (fill_q == FILL_MAX);
        out_account_d = best_acct;
        out_min_d     = best_prod;
        out_idx_d     = best_idx;
        for (int i = 0; i < WIN - 2; i++) begin
          hist_prod_d[i] = hist_prod_q[i+1];
          hist_acct_d[i] = hist_acct_q[i+1];
        end
        hist_prod_d[WIN-2] = s1_prod_q;
        hist_acct_d[WIN-2] = s1_acct_q;
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_prod_q     <= '0;
      s1_acct_q     <= '0;
      fill_q        <= '0;
      out_valid_q   <= 1'b0;
      out_account_q <= '0;
      out_min_q     <= '0;
      out_idx_q     <= '0;
      for (int i = 0; i < WIN - 1; i++) begin
        hist_prod_q[i] <= '0;
        hist_acct_q[i] <= '0;
      end
    end else begin
      ready_en_q    <= ready_en_d;
      s1_valid_q    <= s1_valid_d;
      s1_prod_q     <= s1_prod_d;
      s1_acct_q     <= s1_acct_d;
      fill_q        <= fill_d;
      out_valid_q   <= out_valid_d;
      out_account_q <= out_account_d;
      out_min_q     <= out_min_d;
      out_idx_q     <= out_idx_d;
      for (int i = 0; i < WIN - 1; i++) begin
        hist_prod_q[i] <= hist_prod_d[i];
        hist_acct_q[i] <= hist_acct_d[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_account = out_account_q;
  assign out_min     = out_min_q;
  assign out_idx     = out_idx_q;

endmodule

// File: tb/tb_sliding_window_argmin.sv
// Bench for sliding_window_argmin: directed table plus scoreboarded stream scenarios.
module tb_sliding_window_argmin;
  localparam int WIN = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] in_account = '0, in_A = '0, in_T = '0;

  logic in_ready, out_valid;
  logic [7:0] out_account;
  logic [15:0] out_min;
  logic [2:0] out_idx;

  logic o_in_ready, o_out_valid;
  logic [7:0] o_out_account;
  logic [15:0] o_out_min;
  logic [2:0] o_out_idx;

  logic w_in_ready, w_out_valid;
  logic [7:0] w_out_account;
  logic [15:0] w_out_min;
  logic [0:0] w_out_idx;

  int checks = 0;
  int failures = 0;
  int n_results = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  sliding_window_argmin #(.DSIZE(8), .WIN(5), .TIE_NEWEST(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_account(in_account), .in_A(in_A), .in_T(in_T), .out_valid(out_valid),
    .out_ready(out_ready), .out_account(out_account), .out_min(out_min), .out_idx(out_idx));

  sliding_window_argmin #(.DSIZE(8), .WIN(5), .TIE_NEWEST(0)) dut_old (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(o_in_ready),
    .in_account(in_account), .in_A(in_A), .in_T(in_T), .out_valid(o_out_valid),
    .out_ready(out_ready), .out_account(o_out_account), .out_min(o_out_min), .out_idx(o_out_idx));

  sliding_window_argmin #(.DSIZE(8), .WIN(2), .TIE_NEWEST(1)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_account(in_account), .in_A(in_A), .in_T(in_T), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_account(w_out_account), .out_min(w_out_min), .out_idx(w_out_idx));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Golden model of the main instance (WIN=5, newest wins ties)
  typedef struct { logic [7:0] acct; logic [15:0] mn; int idx; } res_t;
  res_t expq[$];
  int wprod[$];
  logic [7:0] wacct[$];

  function automatic void model_push(input logic [7:0] a, input int p);
    int best;
    int bi;
    res_t r;
    wprod.push_back(p);
    wacct.push_back(a);
    if (wprod.size() > WIN) begin
      void'(wprod.pop_front());
      void'(wacct.pop_front());
    end
    if (wprod.size() == WIN) begin
      best = wprod[0];
      bi = 0;
      for (int j = 1; j < WIN; j++) if (wprod[j] <= best) begin best = wprod[j]; bi = j; end
      r.acct = wacct[bi];
      r.mn = best[15:0];
      r.idx = bi;
      expq.push_back(r);
    end
  endfunction

  logic pv_stall = 1'b0;
  logic [27:0] pv_out = '0;

  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst_n) begin
      expq.delete(); wprod.delete(); wacct.delete();
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) chk("stall_stable", {4'd0, out_valid, out_account, out_min, out_idx}, {4'd0, pv_out});
      if (out_valid && out_ready) begin
        n_results++;
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected actual_acct=%0d expected=no_result", out_account);
        end else begin
          e = expq.pop_front();
          chk("sb_acct", 32'(out_account), 32'(e.acct));
          chk("sb_min", 32'(out_min), 32'(e.mn));
          chk("sb_idx", 32'(out_idx), 32'(e.idx));
        end
      end
      if (in_valid && in_ready) model_push(in_account, int'(in_A) * int'(in_T));
      if (clear) begin expq.delete(); wprod.delete(); wacct.delete(); end
      pv_stall = out_valid && !out_ready && !clear;
      pv_out = {1'b1, out_account, out_min, out_idx};
    end
  end

  typedef struct {
    logic [7:0] acct, a, t;
    logic v; logic [7:0] ea; logic [15:0] em; int ei;
    logic [7:0] oa; int oi;
    logic wv; logic [7:0] wa; logic [15:0] wm; int wi;
  } vec_t;
  vec_t tv [9];

  // Called at posedge+1; returns at the negedge after the result edge
  task automatic apply_one(input logic [7:0] ac, input logic [7:0] a, input logic [7:0] t);
    in_account = ac; in_A = a; in_T = t; in_valid = 1'b1;
    @(negedge clk);
    chk("apply_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] ac, input logic [7:0] a, input logic [7:0] t);
    int n;
    n = 0;
    in_account = ac; in_A = a; in_T = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=0 expected=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int n0;
    int n;
    logic [27:0] cap;

    tv[0] = '{8'd1, 8'd5, 8'd6,    1'b0, 8'd0, 16'd0, 0, 8'd0, 0, 1'b0, 8'd0, 16'd0, 0};
    tv[1] = '{8'd2, 8'd4, 8'd5,    1'b0, 8'd0, 16'd0, 0, 8'd0, 0, 1'b1, 8'd2, 16'd20, 1};
    tv[2] = '{8'd3, 8'd5, 8'd8,    1'b0, 8'd0, 16'd0, 0, 8'd0, 0, 1'b1, 8'd2, 16'd20, 0};
    tv[3] = '{8'd4, 8'd2, 8'd10,   1'b0, 8'd0, 16'd0, 0, 8'd0, 0, 1'b1, 8'd4, 16'd20, 1};
    tv[4] = '{8'd5, 8'd5, 8'd10,   1'b1, 8'd4, 16'd20, 3, 8'd2, 1, 1'b1, 8'd4, 16'd20, 0};
    tv[5] = '{8'd6, 8'd2, 8'd5,    1'b1, 8'd6, 16'd10, 4, 8'd6, 4, 1'b1, 8'd6, 16'd10, 1};
    tv[6] = '{8'd7, 8'd0, 8'd200,  1'b1, 8'd7, 16'd0, 4, 8'd7, 4, 1'b1, 8'd7, 16'd0, 1};
    tv[7] = '{8'd8, 8'd255, 8'd255, 1'b1, 8'd7, 16'd0, 3, 8'd7, 3, 1'b1, 8'd7, 16'd0, 0};
    tv[8] = '{8'd9, 8'd0, 8'd0,    1'b1, 8'd9, 16'd0, 4, 8'd7, 2, 1'b1, 8'd9, 16'd0, 1};

    // Reset state and ready_en start-up
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_account", 32'(out_account), 32'd0);
    chk("rst_out_min", 32'(out_min), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table: main, oldest-tie and WIN=2 instances side by side
    for (int i = 0; i < 9; i++) begin
      apply_one(tv[i].acct, tv[i].a, tv[i].t);
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
      chk($sformatf("tv%0d_old_valid", i), 32'(o_out_valid), 32'(tv[i].v));
      chk($sformatf("tv%0d_w2_valid", i), 32'(w_out_valid), 32'(tv[i].wv));
      if (tv[i].v) begin
        chk($sformatf("tv%0d_acct", i), 32'(out_account), 32'(tv[i].ea));
        chk($sformatf("tv%0d_min", i), 32'(out_min), 32'(tv[i].em));
        chk($sformatf("tv%0d_idx", i), 32'(out_idx), 32'(tv[i].ei));
        chk($sformatf("tv%0d_old_acct", i), 32'(o_out_account), 32'(tv[i].oa));
        chk($sformatf("tv%0d_old_min", i), 32'(o_out_min), 32'(tv[i].em));
        chk($sformatf("tv%0d_old_idx", i), 32'(o_out_idx), 32'(tv[i].oi));
      end
      if (tv[i].wv) begin
        chk($sformatf("tv%0d_w2_acct", i), 32'(w_out_account), 32'(tv[i].wa));
        chk($sformatf("tv%0d_w2_min", i), 32'(w_out_min), 32'(tv[i].wm));
        chk($sformatf("tv%0d_w2_idx", i), 32'(w_out_idx), 32'(tv[i].wi));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("valid_drops_after_gap", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // WIN=2 extreme operands
    pulse_clear();
    apply_one(8'hAA, 8'd255, 8'd255);
    chk("w2_first_no_result", 32'(w_out_valid), 32'd0);
    @(posedge clk); #1;
    apply_one(8'hBB, 8'd255, 8'd255);
    chk("w2_max_valid", 32'(w_out_valid), 32'd1);
    chk("w2_max_min", 32'(w_out_min), 32'd65025);
    chk("w2_max_idx", 32'(w_out_idx), 32'd1);
    chk("w2_max_acct", 32'(w_out_account), 32'hBB);
    @(posedge clk); #1;

    // Clear mid-stream
    pulse_clear();
    n0 = n_results;
    for (int i = 0; i < 7; i++) send(8'(8'h10 + i), 8'(1 + i % 3), 8'(2 + i % 4));
    idle(5);
    chk("clear_pre_results", n_results - n0, 3);
    pulse_clear();
    n0 = n_results;
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 8'(9 - i), 8'd3);
    idle(5);
    chk("clear_partial_none", n_results - n0, 0);
    send(8'h24, 8'd7, 8'd1);
    idle(5);
    chk("clear_fifth_result", n_results - n0, 1);

    // Clear discards a stalled result
    pulse_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 8'(i + 1), 8'd2);
    idle(3);
    chk("stalled_valid", 32'(out_valid), 32'd1);
    chk("stalled_in_ready", 32'(in_ready), 32'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_kills_pending", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    idle(3);

    // Backpressure: 20 records, out_ready held low for 10 cycles once a result shows
    n0 = n_results;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("bp_valid_rises", 32'(out_valid), 32'd1);
        cap = {1'b1, out_account, out_min, out_idx};
        repeat (10) begin
          @(negedge clk);
          chk("bp_in_ready_low", 32'(in_ready), 32'd0);
          chk("bp_out_hold", 32'({out_valid, out_account, out_min, out_idx}), 32'(cap));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("bp_result_count", n_results - n0, 16);

    // Gapped random stream with random downstream stalls; small operands force ties
    pulse_clear();
    n0 = n_results;
    done = 1'b0;
    fork
      begin
        int g;
        for (int i = 0; i < 600; i++) begin
          g = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 150)) : int'($urandom_range(0, 2));
          idle(g);
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("rand_drained", expq.size(), 0);
    chk("rand_result_count", n_results - n0, 596);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 8'd3, 8'd3);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_account", 32'(out_account), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    n0 = n_results;
    for (int i = 0; i < 4; i++) send(8'(8'h50 + i), 8'(4 - i), 8'd5);
    idle(5);
    chk("arst_partial_none", n_results - n0, 0);
    send(8'h54, 8'd1, 8'd1);
    idle(5);
    chk("arst_fifth_result", n_results - n0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sliding_window_argmin.md
Name: sliding_window_argmin

Overview:
- Streaming arg-min engine: accepts (account, A, T) records, forms the product A*T, and for every run of WIN consecutive accepted records emits the account with minimum product.
- Parametrised successor of the fixed 5-deep account-selection stage: width, window depth and tie rule are configurable.
- Adds valid/ready backpressure on both sides and a synchronous stream clear.
- Sits in the single-clock domain downstream of the CDC input buffer.

Parameters:
- DSIZE, 8, width of account, A and T; product width is 2*DSIZE.
- WIN, 5, window depth, legal range 2..16; IW = $clog2(WIN).
- TIE_NEWEST, 1: 1 = on equal products the newest record wins; 0 = the oldest record wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous stream restart; flushes the window.
- in_valid  in  1  input record valid.
- in_ready  out  1  block can accept a record this cycle.
- in_account  in  DSIZE  record account ID.
- in_A  in  DSIZE  operand A, unsigned.
- in_T  in  DSIZE  operand T, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_account  out  DSIZE  account with minimum product in the window.
- out_min  out  2*DSIZE  that minimum product.
- out_idx  out  IW  window position of the winner: 0 = oldest, WIN-1 = newest.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_account=0, out_min=0, out_idx=0, fill=0, s1_valid=0, history cleared to 0.
- in_ready is 0 while rst_n=0 and for the first edge after deassertion; an internal flop sets to 1 on that edge.
- adv = !out_valid || out_ready.
- in_ready = adv && ready_en && !clear.
- A transfer occurs on in_valid && in_ready.
- Stage S1 (on adv): s1_valid <= transfer; s1_prod <= in_A*in_T, full 2*DSIZE bits, no truncation; s1_acct <= in_account.
- Window: history holds WIN-1 past entries (product, account), plus fill counter 0..WIN-1 (saturating).
- Candidate set = history[0..WIN-2] plus the S1 entry as newest.
- On adv && s1_valid:
  - out_valid <= (fill == WIN-1).
  - out_account/out_min/out_idx <= arg-min of the candidate set; strict unsigned compare; ties resolved by TIE_NEWEST.
  - history shifts: oldest dropped, S1 entry appended.
  - fill <= min(fill+1, WIN-1).
- On adv && !s1_valid: out_valid <= 0; data outputs hold their last value.
- On !adv (stall): every register holds, including S1.
  - in_ready=0, so nothing is lost.
  - out_* must remain stable while out_valid && !out_ready.
- Latency: a record accepted at edge k is reflected in a result visible after edge k+1 (two register stages, out_valid high in the cycle following k+1) when no stall occurs.
- Throughput: one result per accepted record once fill==WIN-1.
- N records with no clear produce N-WIN+1 results.
- clear=1 (highest priority after reset):
  - Next edge: fill=0, s1_valid=0, out_valid=0.
  - Any pending unaccepted result is discarded.
  - History contents are don't-care once fill=0.
- clear and in_valid together: the record is not accepted (in_ready=0).
- Fewer than WIN records since reset/clear: no output.
- Maximum operands (A=T=2^DSIZE-1) give product 2^(2*DSIZE)-2^(DSIZE+1)+1, exact.
- Product 0 is a legal minimum.
- Reset mid-stream: all state returns to reset values immediately; no result is produced for partial windows.

Test Plan:
- Basic, WIN=5, TIE_NEWEST=1: accounts 1..5 with products 30,20,40,20,50 -> single result account=4, min=20, idx=3. Then account 6 with A=2,T=5 (product 10) -> account=6, min=10, idx=4.
- Tie rule: same 5 records with TIE_NEWEST=0 -> account=2, min=20, idx=1.
- Backpressure: hold out_ready=0 for 10 cycles during a 20-record stream with in_valid always 1.
  - in_ready drops the cycle after out_valid rises and stays 0.
  - out_* stay stable.
  - After release, exactly 16 results match the software golden model in order; none lost or duplicated.
- Gapped stream: 4000 random records with random 0..150 cycle in_valid gaps -> 3996 results matching the golden model, including last-wins ties.
- Clear mid-stream: feed 7 records, pulse clear, feed 4 records -> 3 results before clear, none after. Then a 5th record -> result computed only from the 5 post-clear records.
- Reset and extremes:
  - rst_n low mid-stream -> out_valid=0, out_account=0, in_ready=0 during reset.
  - WIN=2, DSIZE=8, A=T=255 then A=T=255 -> min=65025, idx=1 (newest).
